// File: rtl/milestone2_writeback_pkg.sv
// milestone2_writeback_pkg: shared states, row widths and segment codes for the write-back stage
package milestone2_writeback_pkg;
  typedef enum logic [1:0] {S_WB_IDLE, S_WB_LEAD, S_WB_WRITE, S_WB_DONE} m2_wb_state_type;
  localparam int Y_WORDS_PER_ROW = 160;
  localparam int UV_WORDS_PER_ROW = 80;
  localparam logic [1:0] SEG_Y = 2'd0;
  localparam logic [1:0] SEG_U = 2'd1;
  localparam logic [1:0] SEG_V = 2'd2;
  function automatic logic params_ok(input logic [1:0] seg, input logic [4:0] row, input logic [5:0] col);
    return seg != 2'd3 && row <= 5'd29 && col <= (seg == SEG_Y ? 6'd39 : 6'd19);
  endfunction
endpackage

// File: rtl/milestone2_writeback_clip.sv
// clip_s32_to_u8: saturate a signed 32-bit sample into the 0..255 pixel range
module clip_s32_to_u8 (
  input  logic [31:0] d_i,
  output logic [7:0]  q_o
);
  assign q_o = d_i[31] ? 8'd0 : (|d_i[30:8] ? 8'd255 : d_i[7:0]);
endmodule

// File: rtl/milestone2_writeback.sv
// milestone2_writeback: clip an 8x8 IDCT block from DP-RAM, pack pixel pairs and write them to SRAM
module milestone2_writeback
  import milestone2_writeback_pkg::*;
#(
  parameter logic [17:0] Y_BASE = 18'd0,
  parameter logic [17:0] U_BASE = 18'd38400,
  parameter logic [17:0] V_BASE = 18'd57600
) (
  input  logic        Clock_50_I,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  segment,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic        busy,
  output logic        done,
  output logic        param_error,
  output logic [5:0]  DP_address_a,
  output logic [5:0]  DP_address_b,
  input  logic [31:0] DP_read_data_a,
  input  logic [31:0] DP_read_data_b,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);
  m2_wb_state_type state_q, state_d;
  logic [1:0]  seg_q, seg_d;
  logic [4:0]  row_q, row_d, j_q, j_d;
  logic [5:0]  col_q, col_d, dpa_q, dpa_d, dpb_q, dpb_d;
  logic        busy_q, busy_d, done_q, done_d, perr_q, perr_d, we_n_q, we_n_d;
  logic [17:0] addr_q, addr_d, base, width, line, wr_addr;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  clip_a, clip_b;
  logic        req, accept, writing;
  clip_s32_to_u8 u_clip_a (.d_i(DP_read_data_a), .q_o(clip_a));
  clip_s32_to_u8 u_clip_b (.d_i(DP_read_data_b), .q_o(clip_b));
  always_comb begin
    req = state_q == S_WB_IDLE && start && !busy_q;
    accept = req && params_ok(segment, block_row, block_col);
    writing = state_q == S_WB_WRITE;
    base = seg_q == SEG_Y ? Y_BASE : (seg_q == SEG_U ? U_BASE : V_BASE);
    width = seg_q == SEG_Y ? 18'(Y_WORDS_PER_ROW) : 18'(UV_WORDS_PER_ROW);
    line = {10'd0, row_q, 3'd0} | {15'd0, j_q[4:2]};
    wr_addr = base + line * width + {10'd0, col_q, 2'd0} + {16'd0, j_q[1:0]};
    state_d = accept ? S_WB_LEAD
            : state_q == S_WB_LEAD ? S_WB_WRITE
            : writing ? (j_q == 5'd31 ? S_WB_DONE : S_WB_WRITE)
            : state_q == S_WB_DONE ? S_WB_IDLE : state_q;
    seg_d = accept ? segment : seg_q;
    row_d = accept ? block_row : row_q;
    col_d = accept ? block_col : col_q;
    j_d = accept ? 5'd0 : (writing ? j_q + 5'd1 : j_q);
    // read addresses stay two words ahead of the write and park on the last pair
    dpa_d = accept ? 6'd0 : state_q == S_WB_LEAD ? 6'd2 : writing ? (dpa_q == 6'd62 ? 6'd62 : dpa_q + 6'd2) : dpa_q;
    dpb_d = accept ? 6'd1 : state_q == S_WB_LEAD ? 6'd3 : writing ? (dpb_q == 6'd63 ? 6'd63 : dpb_q + 6'd2) : dpb_q;
    busy_d = accept || state_q != S_WB_IDLE;
    done_d = state_q == S_WB_DONE;
    perr_d = req && !accept;
    we_n_d = !writing;
    addr_d = writing ? wr_addr : addr_q;
    wdata_d = writing ? {clip_a, clip_b} : wdata_q;
  end
  always_ff @(posedge Clock_50_I) begin
    if (Reset) begin
      state_q <= S_WB_IDLE;
      seg_q <= '0;
      row_q <= '0;
      col_q <= '0;
      j_q <= '0;
      dpa_q <= '0;
      dpb_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
      we_n_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q <= seg_d;
      row_q <= row_d;
      col_q <= col_d;
      j_q <= j_d;
      dpa_q <= dpa_d;
      dpb_q <= dpb_d;
      busy_q <= busy_d;
      done_q <= done_d;
      perr_q <= perr_d;
      we_n_q <= we_n_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign param_error = perr_q;
  assign DP_address_a = dpa_q;
  assign DP_address_b = dpb_q;
  assign SRAM_address = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n = we_n_q;
endmodule
